// File: rtl/biriscv_divider_pkg.sv
// Shared definitions for the iterative RV32M divider: decode constants for
// DIV/DIVU/REM/REMU, the FSM state type and small arithmetic helpers.
package biriscv_divider_pkg;

    // RV32M divide-family instruction mask/match pairs
    localparam logic [31:0] INST_DIV       = 32'h02004033;
    localparam logic [31:0] INST_DIV_MASK  = 32'hfe00707f;
    localparam logic [31:0] INST_DIVU      = 32'h02005033;
    localparam logic [31:0] INST_DIVU_MASK = 32'hfe00707f;
    localparam logic [31:0] INST_REM       = 32'h02006033;
    localparam logic [31:0] INST_REM_MASK  = 32'hfe00707f;
    localparam logic [31:0] INST_REMU      = 32'h02007033;
    localparam logic [31:0] INST_REMU_MASK = 32'hfe00707f;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Two's complement magnitude; 0x80000000 maps onto itself, which the
    // unsigned iteration then treats as 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/biriscv_divider_if.sv
// Issue bundle, stall and writeback signals between the execute stage and
// the divider. The issue side is the master, the divider the slave.
interface biriscv_divider_if;

    logic        opcode_valid;
    logic [31:0] opcode_opcode;
    logic [31:0] opcode_pc;
    logic        opcode_invalid;
    logic [4:0]  opcode_rd_idx;
    logic [4:0]  opcode_ra_idx;
    logic [4:0]  opcode_rb_idx;
    logic [31:0] opcode_ra_operand;
    logic [31:0] opcode_rb_operand;
    logic        hold;
    logic        busy;
    logic        writeback_valid;
    logic [31:0] writeback_value;
    logic [4:0]  writeback_rd_idx;

    modport master (
        output opcode_valid, opcode_opcode, opcode_pc, opcode_invalid,
               opcode_rd_idx, opcode_ra_idx, opcode_rb_idx,
               opcode_ra_operand, opcode_rb_operand, hold,
        input  busy, writeback_valid, writeback_value, writeback_rd_idx
    );

    modport slave (
        input  opcode_valid, opcode_opcode, opcode_pc, opcode_invalid,
               opcode_rd_idx, opcode_ra_idx, opcode_rb_idx,
               opcode_ra_operand, opcode_rb_operand, hold,
        output busy, writeback_valid, writeback_value, writeback_rd_idx
    );

endinterface

// File: rtl/biriscv_divider.sv
// Iterative 32-bit restoring divider for DIV/DIVU/REM/REMU. One operation
// in flight; fixed 33-cycle latency from accept to the writeback strobe.
module biriscv_divider
    import biriscv_divider_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    biriscv_divider_if.slave  bus
);

    div_state_t  state_q, state_d;
    logic [31:0] rem_q, rem_d;
    logic [62:0] divisor_q, divisor_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] qmask_q, qmask_d;
    logic [31:0] dividend_q, dividend_d;
    logic        is_rem_q, is_rem_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic        b_zero_q, b_zero_d;
    logic [4:0]  rd_idx_q, rd_idx_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_value_q, wb_value_d;
    logic [4:0]  wb_rd_q, wb_rd_d;

    logic        inst_div, inst_divu, inst_rem, inst_remu;
    logic        div_inst, is_signed, accept;
    logic [31:0] a_in, b_in, quot_res, rem_res;
    logic        unused_ok;

    assign inst_div  = (bus.opcode_opcode & INST_DIV_MASK)  == INST_DIV;
    assign inst_divu = (bus.opcode_opcode & INST_DIVU_MASK) == INST_DIVU;
    assign inst_rem  = (bus.opcode_opcode & INST_REM_MASK)  == INST_REM;
    assign inst_remu = (bus.opcode_opcode & INST_REMU_MASK) == INST_REMU;
    assign div_inst  = inst_div | inst_divu | inst_rem | inst_remu;
    assign is_signed = inst_div | inst_rem;

    assign bus.busy  = (state_q != ST_IDLE);
    assign accept    = bus.opcode_valid & div_inst & ~bus.opcode_invalid
                     & ~bus.hold & ~bus.busy;

    assign a_in      = bus.opcode_ra_operand;
    assign b_in      = bus.opcode_rb_operand;

    // Divide-by-zero results are forced rather than left to the sign rules
    assign quot_res  = b_zero_q  ? 32'hFFFF_FFFF
                     : neg_quot_q ? neg32(quot_q) : quot_q;
    assign rem_res   = b_zero_q  ? dividend_q
                     : neg_rem_q ? neg32(rem_q) : rem_q;

    assign bus.writeback_valid  = wb_valid_q;
    assign bus.writeback_value  = wb_value_q;
    assign bus.writeback_rd_idx = wb_rd_q;

    // PC and source indices travel with the bundle but play no part here
    assign unused_ok = ^{bus.opcode_pc, bus.opcode_ra_idx, bus.opcode_rb_idx};

    // Next-state logic: 32 iterations in RUN, DONE waits out any hold
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)       state_d = ST_RUN;
            ST_RUN:  if (qmask_q[0])   state_d = ST_DONE;
            ST_DONE: if (!bus.hold)    state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Operand load, one restoring step per RUN cycle, and result selection
    always_comb begin
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        qmask_d    = qmask_q;
        dividend_d = dividend_q;
        is_rem_d   = is_rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        b_zero_d   = b_zero_q;
        rd_idx_d   = rd_idx_q;
        wb_valid_d = 1'b0;
        wb_value_d = wb_value_q;
        wb_rd_d    = wb_rd_q;

        if (state_q == ST_IDLE && accept) begin
            rem_d      = is_signed ? abs32(a_in) : a_in;
            divisor_d  = {(is_signed ? abs32(b_in) : b_in), 31'b0};
            quot_d     = 32'd0;
            qmask_d    = 32'h8000_0000;
            dividend_d = a_in;
            is_rem_d   = inst_rem | inst_remu;
            b_zero_d   = (b_in == 32'd0);
            neg_quot_d = is_signed & (a_in[31] ^ b_in[31]) & (b_in != 32'd0);
            neg_rem_d  = is_signed & a_in[31];
            rd_idx_d   = bus.opcode_rd_idx;
        end else if (state_q == ST_RUN) begin
            if (divisor_q <= {31'b0, rem_q}) begin
                rem_d  = rem_q - divisor_q[31:0];
                quot_d = quot_q | qmask_q;
            end
            divisor_d = divisor_q >> 1;
            qmask_d   = qmask_q >> 1;
        end else if (state_q == ST_DONE && !bus.hold) begin
            wb_valid_d = 1'b1;
            wb_value_d = is_rem_q ? rem_res : quot_res;
            wb_rd_d    = rd_idx_q;
        end
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rem_q      <= 32'd0;
            divisor_q  <= 63'd0;
            quot_q     <= 32'd0;
            qmask_q    <= 32'd0;
            dividend_q <= 32'd0;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            b_zero_q   <= 1'b0;
            rd_idx_q   <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_value_q <= 32'd0;
            wb_rd_q    <= 5'd0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            qmask_q    <= qmask_d;
            dividend_q <= dividend_d;
            is_rem_q   <= is_rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            b_zero_q   <= b_zero_d;
            rd_idx_q   <= rd_idx_d;
            wb_valid_q <= wb_valid_d;
            wb_value_q <= wb_value_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

endmodule

// File: tb/tb_biriscv_divider.sv
// Self-checking bench for biriscv_divider: arithmetic reference model plus
// directed vectors with hand-computed results and latencies.
module tb_biriscv_divider;

    localparam logic [31:0] OP_DIV  = 32'h02004033;
    localparam logic [31:0] OP_DIVU = 32'h02005033;
    localparam logic [31:0] OP_REM  = 32'h02006033;
    localparam logic [31:0] OP_REMU = 32'h02007033;
    localparam logic [31:0] OP_MUL  = 32'h02000033;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    biriscv_divider_if bus();

    biriscv_divider dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Architectural result of an RV32M divide-family instruction
    function automatic logic [31:0] ref_result(input logic [31:0] instr,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [2:0] f3;
        sa = a;
        sb = b;
        f3 = instr[14:12];
        case (f3)
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_divide(input logic [31:0] instr);
        return instr[6:0] == 7'h33 && instr[31:25] == 7'h01 && instr[14];
    endfunction

    // Reference model: one op at a time, 32 working cycles, then the result
    // retires on the first cycle without hold.
    bit          m_busy;
    int          m_cnt;
    logic [31:0] m_val;
    logic [4:0]  m_rd;
    bit          m_strobe;
    logic [31:0] m_last_val;
    logic [4:0]  m_last_rd;

    always @(posedge clk) begin
        m_strobe = 1'b0;
        if (rst) begin
            m_busy     = 1'b0;
            m_cnt      = 0;
            m_last_val = 32'd0;
            m_last_rd  = 5'd0;
        end else if (!m_busy) begin
            if (bus.opcode_valid && !bus.opcode_invalid && !bus.hold
                && is_divide(bus.opcode_opcode)) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_val  = ref_result(bus.opcode_opcode, bus.opcode_ra_operand,
                                    bus.opcode_rb_operand);
                m_rd   = bus.opcode_rd_idx;
            end
        end else if (m_cnt < 32) begin
            m_cnt++;
        end else if (!bus.hold) begin
            m_busy     = 1'b0;
            m_strobe   = 1'b1;
            m_last_val = m_val;
            m_last_rd  = m_rd;
        end
    end

    // Every cycle: outputs must match the model
    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("busy", {31'b0, bus.busy}, {31'b0, m_busy});
            check("wb_valid", {31'b0, bus.writeback_valid}, {31'b0, m_strobe});
            check("wb_value", bus.writeback_value, m_last_val);
            check("wb_rd_idx", {27'b0, bus.writeback_rd_idx}, {27'b0, m_last_rd});
        end
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        bus.opcode_valid      = 1'b1;
        bus.opcode_opcode     = instr | ({27'b0, rd} << 7);
        bus.opcode_rd_idx     = rd;
        bus.opcode_ra_operand = a;
        bus.opcode_rb_operand = b;
    endtask

    task automatic wait_until(input int target);
        for (int k = 0; k < 200 && cyc < target; k++) @(negedge clk);
    endtask

    task automatic wait_strobe(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus.writeback_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Issue one op, optionally hold for hold_n cycles once in DONE, then
    // check the literal result and accept-to-strobe latency.
    task automatic run_op(input string nm, input logic [31:0] instr,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] lit,
                          input int hold_n);
        int c0;
        bit seen;
        @(negedge clk);
        drive(instr, a, b, rd);
        @(negedge clk);
        c0 = cyc;
        bus.opcode_valid = 1'b0;
        if (hold_n > 0) begin
            wait_until(c0 + 32);
            bus.hold = 1'b1;
            for (int k = 0; k < hold_n; k++) @(negedge clk);
            bus.hold = 1'b0;
        end
        wait_strobe(seen);
        check({nm, "_strobe_seen"}, {31'b0, seen}, 32'd1);
        if (seen) begin
            check({nm, "_value"}, bus.writeback_value, lit);
            check({nm, "_rd"}, {27'b0, bus.writeback_rd_idx}, {27'b0, rd});
            check({nm, "_latency"}, cyc - c0, 33 + hold_n);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        bit seen;
        int c0;
        int strobes;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        bus.opcode_valid      = 1'b0;
        bus.opcode_opcode     = 32'd0;
        bus.opcode_pc         = 32'h0000_1000;
        bus.opcode_invalid    = 1'b0;
        bus.opcode_rd_idx     = 5'd0;
        bus.opcode_ra_idx     = 5'd1;
        bus.opcode_rb_idx     = 5'd2;
        bus.opcode_ra_operand = 32'd0;
        bus.opcode_rb_operand = 32'd0;
        bus.hold              = 1'b0;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'h0000_000E};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'h0000_0002};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[4]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[5]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
        vecs[6]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[7]  = '{OP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF};
        vecs[8]  = '{OP_REMU, 32'd5,          32'd0,          32'h0000_0005};
        vecs[9]  = '{OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
        vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[11] = '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'h0000_000E};
        vecs[12] = '{OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE};

        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_wb_valid", {31'b0, bus.writeback_valid}, 32'd0);
        check("reset_wb_value", bus.writeback_value, 32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].instr, vecs[i].a, vecs[i].b,
                   5'(i + 3), vecs[i].exp, 0);

        // Non-divide and faulted instructions are never accepted
        @(negedge clk);
        drive(OP_MUL, 32'd9, 32'd3, 5'd4);
        @(negedge clk);
        check("mul_ignored", {31'b0, bus.busy}, 32'd0);
        drive(OP_DIV, 32'd9, 32'd3, 5'd4);
        bus.opcode_invalid = 1'b1;
        @(negedge clk);
        check("invalid_ignored", {31'b0, bus.busy}, 32'd0);
        bus.opcode_invalid = 1'b0;
        bus.opcode_valid   = 1'b0;

        // Hold in DONE delays the strobe by exactly the hold length
        run_op("hold_done", OP_DIVU, 32'd100, 32'd7, 5'd9, 32'h0000_000E, 3);

        // Hold during RUN does not stall the iterations
        @(negedge clk);
        drive(OP_REMU, 32'd1000, 32'd33, 5'd10);
        @(negedge clk);
        c0 = cyc;
        bus.opcode_valid = 1'b0;
        wait_until(c0 + 10);
        bus.hold = 1'b1;
        wait_until(c0 + 14);
        bus.hold = 1'b0;
        wait_strobe(seen);
        check("hold_run_seen", {31'b0, seen}, 32'd1);
        check("hold_run_latency", cyc - c0, 33);
        check("hold_run_value", bus.writeback_value, 32'd10);

        // Back-to-back: second op held on the bus is accepted at E34
        @(negedge clk);
        drive(OP_DIVU, 32'd100, 32'd7, 5'd1);
        @(negedge clk);
        c0 = cyc;
        drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd2);
        wait_until(c0 + 33);
        check("b2b_first_strobe", {31'b0, bus.writeback_valid}, 32'd1);
        check("b2b_first_rd", {27'b0, bus.writeback_rd_idx}, 32'd1);
        check("b2b_first_value", bus.writeback_value, 32'h0000_000E);
        @(negedge clk);
        check("b2b_second_accept", {31'b0, bus.busy}, 32'd1);
        bus.opcode_valid = 1'b0;
        wait_strobe(seen);
        check("b2b_second_seen", {31'b0, seen}, 32'd1);
        check("b2b_second_cycle", cyc - c0, 67);
        check("b2b_second_rd", {27'b0, bus.writeback_rd_idx}, 32'd2);
        check("b2b_second_value", bus.writeback_value, 32'hFFFF_FFFD);

        // Reset mid-RUN aborts with no strobe
        @(negedge clk);
        drive(OP_DIVU, 32'd50, 32'd5, 5'd7);
        @(negedge clk);
        c0 = cyc;
        bus.opcode_valid = 1'b0;
        wait_until(c0 + 10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy_cleared", {31'b0, bus.busy}, 32'd0);
        check("rst_value_cleared", bus.writeback_value, 32'd0);
        strobes = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.writeback_valid) strobes++;
        end
        check("rst_no_strobe", strobes, 0);

        // Still functional after the abort
        run_op("post_rst", OP_DIVU, 32'd50, 32'd5, 5'd8, 32'h0000_000A, 0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
